// File: rtl/dsp_stream_pkg.sv
// Shared constants for the DSP stream stages.
// DECIM_TLAST_EN (frame tlast on the decimator) is left undefined by default.
package dsp_stream_pkg;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned RW_DEFAULT = 16;
    localparam int unsigned RATE_MIN   = 1;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI-Stream output slot; a new word may load on the
// same edge the held word is taken, so full throughput needs no skid buffer.
module axis_out_reg
    import dsp_stream_pkg::*;
#(
    parameter int unsigned W = DW_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_in_ready,
    output logic         o_emit,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] r_data;
    logic         r_valid;

    assign o_in_ready = ce & (~r_valid | i_ready);
    assign o_emit     = ce & r_valid & i_ready;
    assign o_data     = r_data;
    assign o_valid    = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (ce) begin
            if (i_load) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (o_emit) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_decimator.sv
// Keeps the first of every max(rate,1) accepted samples; bypass when enable=0.
// Define DECIM_TLAST_EN to add tlast_m marking every FRAME_LEN-th output.
module stream_decimator
    import dsp_stream_pkg::*;
#(
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned RW        = RW_DEFAULT,
    parameter int unsigned FRAME_LEN = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          enable,
    input  logic [RW-1:0] rate,
    input  logic [DW-1:0] tdata_s,
    input  logic          tvalid_s,
    output logic          tready_s,
    output logic [DW-1:0] tdata_m,
    output logic          tvalid_m,
`ifdef DECIM_TLAST_EN
    output logic          tlast_m,
`endif
    input  logic          tready_m
);

`ifdef DECIM_TLAST_EN
    localparam int unsigned PW = DW + 1;
`else
    localparam int unsigned PW = DW;
`endif

    logic          w_in_ready;
    logic          w_accept;
    logic          w_keep;
    logic          w_emit;
    logic          w_phase_zero;
    logic [RW-1:0] w_rate_in;
    logic [RW-1:0] w_eff_rate;
    logic [RW-1:0] w_phase_d;
    logic [RW-1:0] w_rate_d;
    logic [RW-1:0] r_phase;
    logic [RW-1:0] r_rate_q;
    logic [PW-1:0] w_slot_in;
    logic [PW-1:0] w_slot_out;

    assign tready_s     = w_in_ready;
    assign w_accept     = ce & tvalid_s & w_in_ready;
    assign w_rate_in    = (rate < RW'(RATE_MIN)) ? RW'(RATE_MIN) : rate;
    assign w_phase_zero = (r_phase == '0);
    // A period boundary picks up the live rate so the wrap compares against it.
    assign w_eff_rate   = w_phase_zero ? w_rate_in : r_rate_q;
    assign w_keep       = w_accept & (~enable | w_phase_zero);

    always_comb begin
        w_phase_d = r_phase;
        w_rate_d  = r_rate_q;
        if (!enable) begin
            w_phase_d = '0;
            w_rate_d  = w_rate_in;
        end else if (w_accept) begin
            if (w_phase_zero) begin
                w_rate_d = w_rate_in;
            end
            w_phase_d = (r_phase == w_eff_rate - RW'(1)) ? '0 : r_phase + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase  <= '0;
            r_rate_q <= RW'(RATE_MIN);
        end else if (ce) begin
            r_phase  <= w_phase_d;
            r_rate_q <= w_rate_d;
        end
    end

`ifdef DECIM_TLAST_EN
    localparam int unsigned FW = cnt_width(FRAME_LEN);

    logic [FW-1:0] r_frame_cnt;
    logic [FW-1:0] w_frame_next;
    logic [FW-1:0] w_pos;
    logic          r_enable_q;
    logic          w_last;

    assign w_frame_next = (r_frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : r_frame_cnt + FW'(1);
    // A load only happens into an empty slot or alongside an emit, so the
    // loaded word's frame position is the emit count after this edge.
    assign w_pos        = w_emit ? w_frame_next : r_frame_cnt;
    assign w_last       = (w_pos == FW'(FRAME_LEN - 1));
    assign w_slot_in    = {w_last, tdata_s};
    assign tlast_m      = w_slot_out[DW];
    assign tdata_m      = w_slot_out[DW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_enable_q  <= 1'b0;
        end else if (ce) begin
            r_enable_q <= enable;
            if (r_enable_q & ~enable) begin
                r_frame_cnt <= '0;
            end else if (w_emit) begin
                r_frame_cnt <= w_frame_next;
            end
        end
    end
`else
    assign w_slot_in = tdata_s;
    assign tdata_m   = w_slot_out;
`endif

    axis_out_reg #(
        .W(PW)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .i_load    (w_keep),
        .i_data    (w_slot_in),
        .i_ready   (tready_m),
        .o_in_ready(w_in_ready),
        .o_emit    (w_emit),
        .o_data    (w_slot_out),
        .o_valid   (tvalid_m)
    );

endmodule

// File: tb/tb_stream_decimator.sv
// Scoreboard bench for stream_decimator: directed plan cases plus random traffic.
module tb_stream_decimator;

    localparam int unsigned FL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        enable;
    logic [15:0] rate;
    logic [15:0] tdata_s;
    logic        tvalid_s;
    logic        tready_s;
    logic [15:0] tdata_m;
    logic        tvalid_m;
    logic        tready_m;
`ifdef DECIM_TLAST_EN
    logic        tlast_m;
`endif

    stream_decimator #(
        .DW       (16),
        .RW       (16),
        .FRAME_LEN(FL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .enable  (enable),
        .rate    (rate),
        .tdata_s (tdata_s),
        .tvalid_s(tvalid_s),
        .tready_s(tready_s),
        .tdata_m (tdata_m),
        .tvalid_m(tvalid_m),
`ifdef DECIM_TLAST_EN
        .tlast_m (tlast_m),
`endif
        .tready_m(tready_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        bit          l;
    } item_t;

    item_t sb[$];
    item_t got[$];
    int    exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    acc_flag = 0;
    bit    chk_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one-slot output buffer plus period bookkeeping in plain integers.
    initial begin : model
        int  pending;
        int  pos;
        int  plen;
        int  kept_cnt;
        bit  prev_en;
        bit  rdy;
        bit  emit;
        bit  acc;
        bit  keep;
        item_t it;
        pending = 0; pos = 0; plen = 1; kept_cnt = 0; prev_en = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending = 0; pos = 0; plen = 1; kept_cnt = 0; prev_en = 0;
                acc_flag = 0;
                sb.delete();
            end else begin
                rdy  = ce && (pending == 0 || tready_m);
                check("tready_s", 32'(tready_s), 32'(rdy));
                check("tvalid_m", 32'(tvalid_m), 32'(pending != 0));
                emit = ce && pending != 0 && tready_m;
                acc  = ce && tvalid_s && rdy;
                keep = 0;
                if (ce) begin
                    if (!enable) begin
                        pos  = 0;
                        keep = acc;
                    end else if (acc) begin
                        if (pos == 0) begin
                            plen = (rate == 0) ? 1 : int'(rate);
                            keep = 1;
                        end
                        pos = (pos + 1) % plen;
                    end
                    if (keep) begin
                        it.d = tdata_s;
                        it.l = (kept_cnt % FL) == FL - 1;
                        kept_cnt++;
                        sb.push_back(it);
                    end
                    if (prev_en && !enable) kept_cnt = 0;
                    prev_en = enable;
                end
                pending  = pending - int'(emit) + int'(keep);
                acc_flag = acc;
            end
        end
    end

    initial begin : monitor
        item_t       e;
        item_t       a;
        bit          hold_prev;
        logic [15:0] prev_data;
        hold_prev = 0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset && hold_prev) check("stall_stable", 32'(tdata_m), 32'(prev_data));
            if (!reset && ce && tvalid_m === 1'b1 && tready_m) begin
                a.d = tdata_m;
`ifdef DECIM_TLAST_EN
                a.l = tlast_m;
`else
                a.l = 0;
`endif
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h, expected none", tdata_m);
                end else begin
                    e = sb.pop_front();
                    check("tdata_m", 32'(a.d), 32'(e.d));
                    if (chk_last) check("tlast_m", 32'(a.l), 32'(e.l));
                end
                got.push_back(a);
            end
            hold_prev = !reset && tvalid_m === 1'b1 && !(ce && tready_m);
            prev_data = tdata_m;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tvalid_s = 1'b0;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic drive(input int v);
        int t;
        t = 0;
        tdata_s  = 16'(v);
        tvalid_s = 1'b1;
        do begin
            step();
            t++;
        end while (!acc_flag && t < 200);
        if (!acc_flag) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept, expected accept of %0d", v);
        end
        tvalid_s = 1'b0;
    endtask

    task automatic set_seq(input int start, input int stp, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + i * stp);
    endtask

    task automatic check_got(input string name);
        check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check(name, 32'(got[i].d), 32'(exp_q[i]));
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b1; ce = 1'b1; enable = 1'b1; rate = 16'd4;
        tdata_s = '0; tvalid_s = 1'b0; tready_m = 1'b1;
        idle(3);
        check("reset_tvalid", 32'(tvalid_m), 32'd0);
        check("reset_tdata", 32'(tdata_m), 32'd0);
        reset = 1'b0;
        step();
        check("idle_tready", 32'(tready_s), 32'd1);

        // Decimate by 4, no backpressure.
        got.delete();
        for (int i = 0; i < 16; i++) drive(i);
        idle(4);
        set_seq(0, 4, 4);
        check_got("dec4");

        // Backpressure with rate 2.
        do_reset();
        rate = 16'd2;
        fork
            begin
                for (int i = 0; i < 8; i++) drive(i);
            end
            begin
                tready_m = 1'b1;
                idle(3);
                tready_m = 1'b0;
                idle(6);
                tready_m = 1'b1;
            end
        join
        idle(4);
        set_seq(0, 2, 4);
        check_got("backpressure");

        // Rate change mid-period takes effect at the next boundary.
        do_reset();
        rate = 16'd4;
        for (int i = 0; i < 12; i++) begin
            drive(i);
            if (i == 2) rate = 16'd3;
        end
        idle(4);
        exp_q.delete();
        exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(7); exp_q.push_back(10);
        check_got("rate_change");

        // rate 0 and 1 keep everything; bypass ignores rate.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            rate = 16'(r);
            for (int i = 0; i < 8; i++) drive(i);
            idle(3);
            set_seq(0, 1, 8);
            check_got(r == 0 ? "rate0" : "rate1");
        end
        do_reset();
        enable = 1'b0;
        rate = 16'd8;
        for (int i = 0; i < 8; i++) drive(i);
        idle(3);
        set_seq(0, 1, 8);
        check_got("bypass");
        enable = 1'b1;

        // Reset while holding an output, then a ce freeze.
        do_reset();
        rate = 16'd4;
        tready_m = 1'b0;
        drive(5);
        check("held_valid", 32'(tvalid_m), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_clr_valid", 32'(tvalid_m), 32'd0);
        check("rst_clr_data", 32'(tdata_m), 32'd0);
        drive(9);
        check("post_rst_valid", 32'(tvalid_m), 32'd1);
        check("post_rst_data", 32'(tdata_m), 32'd9);
        ce = 1'b0;
        tvalid_s = 1'b1;
        tdata_s = 16'd6;
        tready_m = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ce0_no_accept", 32'(acc_flag), 32'd0);
            check("ce0_valid", 32'(tvalid_m), 32'd1);
            check("ce0_data", 32'(tdata_m), 32'd9);
        end
        ce = 1'b1;
        tvalid_s = 1'b0;
        idle(3);
        set_seq(9, 1, 1);
        check_got("ce_freeze");

`ifdef DECIM_TLAST_EN
        do_reset();
        rate = 16'd2;
        chk_last = 1;
        for (int i = 0; i < 16; i++) drive(i);
        idle(4);
        chk_last = 0;
        for (int i = 0; i < got.size(); i++) begin
            check("tlast_pos", 32'(got[i].l), 32'(got[i].d == 6 || got[i].d == 14));
        end
        set_seq(0, 2, 8);
        check_got("tlast_data");
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            step();
            ce       = ($urandom % 8) != 0;
            tvalid_s = ($urandom % 4) != 0;
            tdata_s  = 16'($urandom);
            tready_m = ($urandom % 3) != 0;
            if ($urandom % 40 == 0) enable = ~enable;
            if ($urandom % 25 == 0) rate = 16'($urandom_range(0, 5));
        end
        step();
        ce = 1'b1;
        tvalid_s = 1'b0;
        tready_m = 1'b1;
        enable = 1'b1;
        idle(5);
        check("drained", 32'(sb.size()), 32'd0);
        got.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
